// File: rtl/ex_pkg.sv
// Shared types and constants for the THCO-MIPS execute stage.
// The optional divider is enabled by defining EX_DIV_EN; see ex_multicycle.sv.
package ex_pkg;

   localparam int ALU_OP_W = 4;

   // Operation codes presented by decode; 4'hF is deliberately unassigned.
   typedef enum logic [ALU_OP_W-1:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_NOT  = 4'd5,
      OP_SLL  = 4'd6,
      OP_SRL  = 4'd7,
      OP_SRA  = 4'd8,
      OP_SLT  = 4'd9,
      OP_SLTU = 4'd10,
      OP_CMP  = 4'd11,
      OP_MUL  = 4'd12,
      OP_DIV  = 4'd13,
      OP_REM  = 4'd14
   } alu_op_t;

   // Iterative unit state.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } fsm_state_t;

   // Operation selector for the iterative unit.
   typedef enum logic [1:0] {
      MD_MUL = 2'd0,
      MD_DIV = 2'd1,
      MD_REM = 2'd2
   } md_op_t;

   localparam int ZeroWord = 0;

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative signed multiply / divide / remainder unit.
// Operands are converted to magnitudes on start, one shift-add or restoring
// subtract step runs per BUSY cycle, and the sign is restored while in DONE.
// The divide path exists only when EX_DIV_EN is defined.
module ex_muldiv_iter import ex_pkg::*; #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  md_op_t            op,
   input  logic [DATA_W-1:0] op1,
   input  logic [DATA_W-1:0] op2,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              dbz,
   output fsm_state_t        state
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [CNT_W-1:0]  cnt;
   md_op_t            op_q;
   logic [DATA_W-1:0] a_q;    // MUL: shifting multiplicand; DIV/REM: divisor
   logic [DATA_W-1:0] b_q;    // MUL: shifting multiplier;   DIV/REM: dividend -> quotient
   logic [DATA_W-1:0] acc_q;  // MUL: product;               DIV/REM: partial remainder
   logic              neg_q;  // result (product or quotient) must be negated
   logic              dbz_q;
   logic [DATA_W-1:0] a_nxt, b_nxt, acc_nxt;
   logic [DATA_W-1:0] mag1, mag2;
`ifdef EX_DIV_EN
   logic              neg_rem_q;  // remainder takes the dividend's sign
   logic [DATA_W:0]   rtmp, rdiff;
`endif

   assign mag1 = op1[DATA_W-1] ? -op1 : op1;
   assign mag2 = op2[DATA_W-1] ? -op2 : op2;

   // One iteration step computed from the current working registers.
   always_comb begin
      a_nxt   = a_q;
      b_nxt   = b_q;
      acc_nxt = acc_q;
`ifdef EX_DIV_EN
      rtmp    = '0;
      rdiff   = '0;
`endif
      if (op_q == MD_MUL) begin
         if (b_q[0]) acc_nxt = acc_q + a_q;
         a_nxt = a_q << 1;
         b_nxt = b_q >> 1;
      end
`ifdef EX_DIV_EN
      else begin
         rtmp  = {acc_q, b_q[DATA_W-1]};
         rdiff = rtmp - {1'b0, a_q};
         if (rtmp >= {1'b0, a_q}) begin
            acc_nxt = rdiff[DATA_W-1:0];
            b_nxt   = {b_q[DATA_W-2:0], 1'b1};
         end else begin
            acc_nxt = rtmp[DATA_W-1:0];
            b_nxt   = {b_q[DATA_W-2:0], 1'b0};
         end
      end
`endif
   end

   // Control FSM with the step counter and working registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         op_q  <= MD_MUL;
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         neg_q <= 1'b0;
         dbz_q <= 1'b0;
`ifdef EX_DIV_EN
         neg_rem_q <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !flush) begin
                  op_q  <= op;
                  dbz_q <= 1'b0;
                  cnt   <= CNT_W'(DATA_W);
                  if (op == MD_MUL) begin
                     a_q   <= mag1;
                     b_q   <= mag2;
                     acc_q <= '0;
                     neg_q <= op1[DATA_W-1] ^ op2[DATA_W-1];
                     state <= ST_BUSY;
                  end
`ifdef EX_DIV_EN
                  else if (op2 == '0) begin
                     // Quotient all ones, remainder is the raw dividend.
                     a_q       <= '0;
                     b_q       <= '1;
                     acc_q     <= op1;
                     neg_q     <= 1'b0;
                     neg_rem_q <= 1'b0;
                     dbz_q     <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     a_q       <= mag2;
                     b_q       <= mag1;
                     acc_q     <= '0;
                     neg_q     <= op1[DATA_W-1] ^ op2[DATA_W-1];
                     neg_rem_q <= op1[DATA_W-1];
                     state     <= ST_BUSY;
                  end
`endif
               end
            end
            ST_BUSY: begin
               if (flush) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  a_q   <= a_nxt;
                  b_q   <= b_nxt;
                  acc_q <= acc_nxt;
                  cnt   <= cnt - 1'b1;
                  if (cnt == CNT_W'(1)) state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sign correction of the finished result; zero outside DONE.
   always_comb begin
      result = '0;
      if (state == ST_DONE) begin
         case (op_q)
            MD_MUL:  result = neg_q ? -acc_q : acc_q;
`ifdef EX_DIV_EN
            MD_DIV:  result = neg_q ? -b_q : b_q;
            MD_REM:  result = neg_rem_q ? -acc_q : acc_q;
`endif
            default: result = '0;
         endcase
      end
   end

   assign busy = (state == ST_BUSY);
   assign done = (state == ST_DONE);
   assign dbz  = done & dbz_q;

endmodule

// File: rtl/ex_multicycle.sv
// Execute stage: combinational ALU plus an iterative mul/div unit that stalls
// upstream while it runs. Define EX_DIV_EN to implement DIV/REM; otherwise
// they decode as undefined codes (result 0, no stall).
module ex_multicycle import ex_pkg::*; #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 4,
   parameter int SHAMT_W    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ALU_OP_W-1:0]   aluOp_i,
   input  logic [DATA_W-1:0]     operand1_i,
   input  logic [DATA_W-1:0]     operand2_i,
   input  logic                  wReg_i,
   input  logic [REG_ADDR_W-1:0] wRegAddr_i,
   input  logic                  flush_i,
   output logic [DATA_W-1:0]     wData_o,
   output logic                  wReg_o,
   output logic [REG_ADDR_W-1:0] wRegAddr_o,
   output logic                  stallReq_o,
   output logic                  divByZero_o
);

   alu_op_t           op;
   logic              is_multi;
   md_op_t            md_op;
   logic              md_busy, md_done, md_dbz;
   logic [DATA_W-1:0] md_result;
   fsm_state_t        md_state;
   logic [SHAMT_W-1:0] s_field;
   logic [SHAMT_W:0]  shamt;
   logic [DATA_W-1:0] alu_res;
   logic              stall_req;

   assign op      = alu_op_t'(aluOp_i);
   assign s_field = operand2_i[SHAMT_W-1:0];
   // A zero field means a full 2^SHAMT_W shift.
   assign shamt   = {(s_field == '0), s_field};

   // Decode which codes go to the iterative unit.
   always_comb begin
      is_multi = 1'b0;
      md_op    = MD_MUL;
      case (op)
         OP_MUL: is_multi = 1'b1;
`ifdef EX_DIV_EN
         OP_DIV: begin is_multi = 1'b1; md_op = MD_DIV; end
         OP_REM: begin is_multi = 1'b1; md_op = MD_REM; end
`endif
         default: ;
      endcase
   end

   // Single-cycle ALU.
   always_comb begin
      alu_res = DATA_W'(ZeroWord);
      case (op)
         OP_ADD:  alu_res = operand1_i + operand2_i;
         OP_SUB:  alu_res = operand1_i - operand2_i;
         OP_AND:  alu_res = operand1_i & operand2_i;
         OP_OR:   alu_res = operand1_i | operand2_i;
         OP_NOT:  alu_res = ~operand1_i;
         OP_SLL:  alu_res = operand1_i << shamt;
         OP_SRL:  alu_res = operand1_i >> shamt;
         OP_SRA:  alu_res = $signed(operand1_i) >>> shamt;
         OP_SLT:  alu_res = DATA_W'($signed(operand1_i) < $signed(operand2_i));
         OP_SLTU: alu_res = DATA_W'(operand1_i < operand2_i);
         OP_CMP:  alu_res = DATA_W'(operand1_i != operand2_i);
         default: alu_res = DATA_W'(ZeroWord);
      endcase
   end

   ex_muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (is_multi),
      .op     (md_op),
      .op1    (operand1_i),
      .op2    (operand2_i),
      .flush  (flush_i),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result),
      .dbz    (md_dbz),
      .state  (md_state)
   );

   // Stall while a multi-cycle op is being accepted or iterating.
   assign stall_req = !flush_i && ((md_state == ST_IDLE && is_multi) || md_busy);

   // Output mux: reset forces zeros, stall inserts a bubble, flush kills writeback.
   always_comb begin
      wData_o     = DATA_W'(ZeroWord);
      wReg_o      = 1'b0;
      wRegAddr_o  = '0;
      stallReq_o  = 1'b0;
      divByZero_o = 1'b0;
      if (rst) begin
         wRegAddr_o = wRegAddr_i;
         stallReq_o = stall_req;
         if (md_done) begin
            wData_o     = md_result;
            divByZero_o = md_dbz;
            wReg_o      = wReg_i & ~flush_i;
         end else if (!stall_req) begin
            wData_o = alu_res;
            wReg_o  = wReg_i & ~flush_i;
         end
      end
   end

endmodule

// File: tb/tb_ex_multicycle.sv
// Directed and randomized bench for ex_multicycle with an arithmetic reference model.
module tb_ex_multicycle;
   import ex_pkg::*;

   localparam int DW = 16;
`ifdef EX_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [3:0]    alu_op = 4'd0;
   logic [DW-1:0] op1 = '0, op2 = '0;
   logic          wreg = 1'b0;
   logic [3:0]    waddr = '0;
   logic          flush = 1'b0;
   logic [DW-1:0] wdata;
   logic          wreg_o, stall, dbz;
   logic [3:0]    waddr_o;

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] exp_q[$];

   ex_multicycle #(.DATA_W(DW), .REG_ADDR_W(4), .SHAMT_W(3)) dut (
      .clk(clk), .rst(rst), .aluOp_i(alu_op), .operand1_i(op1), .operand2_i(op2),
      .wReg_i(wreg), .wRegAddr_i(waddr), .flush_i(flush),
      .wData_o(wdata), .wReg_o(wreg_o), .wRegAddr_o(waddr_o),
      .stallReq_o(stall), .divByZero_o(dbz)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model from the arithmetic definition of each operation.
   function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, output bit ezero,
                                           output int stalls);
      int sa, sb, s;
      logic [DW-1:0] r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      s  = (b[2:0] == 3'd0) ? 8 : int'(b[2:0]);
      ezero = 1'b0;
      stalls = 0;
      r = '0;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_NOT:  r = ~a;
         OP_SLL:  r = a << s;
         OP_SRL:  r = a >> s;
         OP_SRA:  r = DW'(sa >>> s);
         OP_SLT:  r = (sa < sb) ? 16'd1 : 16'd0;
         OP_SLTU: r = (a < b) ? 16'd1 : 16'd0;
         OP_CMP:  r = (a == b) ? 16'd0 : 16'd1;
         OP_MUL:  begin r = DW'(sa * sb); stalls = DW + 1; end
         OP_DIV, OP_REM: begin
            if (DIV_EN) begin
               if (b == '0) begin
                  r = (op == OP_DIV) ? 16'hFFFF : a;
                  ezero = 1'b1;
                  stalls = 1;
               end else begin
                  stalls = DW + 1;
                  if (sa == -32768 && sb == -1) r = (op == OP_DIV) ? 16'h8000 : 16'h0000;
                  else r = (op == OP_DIV) ? DW'(sa / sb) : DW'(sa % sb);
               end
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Present one instruction at posedge+1, wait out any stall, check the result.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
      bit edbz;
      int est, n;
      bit bubble_ok;
      logic [DW-1:0] got;
      exp_q.push_back(model(op, a, b, edbz, est));
      alu_op = op; op1 = a; op2 = b;
      wreg = 1'($urandom_range(0, 1));
      waddr = 4'($urandom_range(0, 15));
      n = 0;
      bubble_ok = 1'b1;
      @(negedge clk);
      while (stall === 1'b1 && n < 40) begin
         if (wreg_o !== 1'b0 || wdata !== '0) bubble_ok = 1'b0;
         n++;
         @(negedge clk);
      end
      got = wdata;
      check({tag, "_stalls"}, 32'(n), 32'(est));
      check({tag, "_bubble"}, 32'(bubble_ok), 32'd1);
      check({tag, "_data"}, 32'(got), 32'(exp_q.pop_front()));
      check({tag, "_dbz"}, 32'(dbz), 32'(edbz));
      check({tag, "_wreg"}, {27'd0, wreg_o, waddr_o}, {27'd0, wreg, waddr});
      @(posedge clk); #1;
   endtask

   initial begin
      logic [3:0] rop;
      logic [DW-1:0] ra, rb;
      // Reset with live-looking inputs: outputs must all be zero.
      alu_op = OP_ADD; op1 = 16'h0005; wreg = 1'b1; waddr = 4'd7;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outs", {13'd0, wdata, wreg_o, waddr_o, stall, dbz}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Directed single-cycle ops.
      run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001);
      run_op("sra_s0", OP_SRA, 16'h8000, 16'h0000);
      run_op("slt", OP_SLT, 16'h8000, 16'h0001);
      run_op("sltu", OP_SLTU, 16'h8000, 16'h0001);
      run_op("sll3", OP_SLL, 16'h00F1, 16'h0003);
      run_op("cmp_eq", OP_CMP, 16'h1234, 16'h1234);
      run_op("undef", 4'hF, 16'h1234, 16'h0001);

      // Directed multi-cycle ops.
      run_op("mul", OP_MUL, 16'h0003, 16'hFFFE);
      run_op("div", OP_DIV, 16'hFFF9, 16'h0002);
      run_op("rem", OP_REM, 16'hFFF9, 16'h0002);
      run_op("div_ovf", OP_DIV, 16'h8000, 16'hFFFF);
      run_op("div_zero", OP_DIV, 16'h1234, 16'h0000);
      run_op("rem_zero", OP_REM, 16'h1234, 16'h0000);
      run_op("div_6_3", OP_DIV, 16'h0006, 16'h0003);

      // Flush in the middle of a multiply.
      alu_op = OP_MUL; op1 = 16'h0003; op2 = 16'h0005; wreg = 1'b1; waddr = 4'd3;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("flush_pre_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      check("flush_cycle", {30'd0, stall, wreg_o}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      run_op("after_flush_add", OP_ADD, 16'h0010, 16'h0020);
      run_op("after_flush_mul", OP_MUL, 16'hFFFF, 16'hFFFF);

      // Reset in the middle of an iterative op.
      alu_op = DIV_EN ? OP_DIV : OP_MUL;
      op1 = 16'd100; op2 = 16'd7; wreg = 1'b1; waddr = 4'd9;
      repeat (8) @(posedge clk);
      #1 rst = 1'b0;
      #1 check("mid_reset_outs", {13'd0, wdata, wreg_o, waddr_o, stall, dbz}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      run_op("after_rst_add", OP_ADD, 16'h0001, 16'h0002);
      run_op("after_rst_div", OP_DIV, 16'd100, 16'hFFF9);

      // Randomized mix, biased toward interesting operands.
      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 7))
            0: rb = 16'h0000;
            1: begin ra = 16'h8000; rb = 16'hFFFF; end
            2: rb = 16'($urandom_range(0, 7));
            default: ;
         endcase
         run_op("rand", rop, ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ex_multicycle.md
# ex_multicycle

Parametrised execute stage for the THCO-MIPS pipeline. It sits between the ID/EX and EX/MEM pipeline registers.
- Single-cycle ops: arithmetic, logic, shift and compare complete combinationally.
- Multi-cycle ops: signed multiply, divide and remainder run through an internal iterative FSM.
- While a multi-cycle op runs, the block raises a stall request that freezes PC, IF/ID and ID/EX.

## Interface
- DATA_W, 16, datapath width (≥ 8, even)
- REG_ADDR_W, 4, register-address width
- SHAMT_W, 3, shift-amount field width; field value 0 encodes a shift of 2^SHAMT_W
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- aluOp_i  in  ALU_OP_W  operation code (package enum)
- operand1_i  in  DATA_W  first operand
- operand2_i  in  DATA_W  second operand / shift amount
- wReg_i  in  1  writeback enable from decode
- wRegAddr_i  in  REG_ADDR_W  writeback register address
- flush_i  in  1  abort current instruction (branch/exception)
- wData_o  out  DATA_W  result
- wReg_o  out  1  writeback enable to MEM
- wRegAddr_o  out  REG_ADDR_W  writeback address to MEM
- stallReq_o  out  1  hold upstream stages this cycle
- divByZero_o  out  1  divide/remainder by zero flag, valid with the result

## Operation
- Single-cycle ops, combinational:
  - ADD, SUB, AND, OR, NOT (~op1), SLT (signed), SLTU (unsigned) → 1/0.
  - CMP → 0 if equal, else 1.
  - SLL, SRL, SRA by s = operand2_i[SHAMT_W-1:0], where s = 0 means 2^SHAMT_W. SRA sign-fills.
  - NOP and undefined codes → wData_o = 0.
- Multi-cycle ops:
  - MUL: signed, result is the low DATA_W bits of the product.
  - DIV: signed quotient, truncating toward zero.
  - REM: signed remainder, sign follows the dividend.
  - Operands are magnitude-converted at start; the result is sign-corrected in DONE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY when aluOp_i ∈ {MUL, DIV, REM} and flush_i = 0. Operands are latched and the step counter is set to DATA_W.
  - IDLE → DONE directly for DIV/REM with operand2_i = 0.
  - BUSY: one shift-add (MUL) or restoring subtract (DIV/REM) step per cycle, counter decrements. BUSY → DONE when the counter reaches 1.
  - DONE → IDLE unconditionally.
- stallReq_o = 1 in IDLE when a multi-cycle op is presented, and throughout BUSY; 0 in DONE.
- While stallReq_o = 1: wReg_o = 0 and wData_o = 0, so the EX/MEM register captures a bubble.
- In DONE:
  - wData_o = final result; wReg_o/wRegAddr_o pass wReg_i/wRegAddr_i, which upstream holds stable.
  - Divide by zero: quotient = all ones, remainder = operand1, divByZero_o = 1.
  - Overflow (MIN ÷ −1): quotient = MIN, remainder = 0, no flag.
- Outside multi-cycle ops: wReg_o = wReg_i, wRegAddr_o = wRegAddr_i.
- flush_i = 1 in any state:
  - wReg_o = 0 and stallReq_o = 0 that cycle.
  - FSM → IDLE at the next edge; the latched operands are discarded.
- rst = 0, at any time including mid-BUSY:
  - FSM = IDLE, counter = 0, internal accumulators = 0.
  - All outputs forced 0: wData_o, wReg_o, wRegAddr_o, stallReq_o, divByZero_o.

## Timing
- Single-cycle ops: zero-cycle combinational latency.
- MUL/DIV/REM: op presented in cycle 0, result in cycle DATA_W+1.
  - stallReq_o high during cycles 0 … DATA_W.
  - Total occupancy is DATA_W+2 cycles (17+1 = 18 at the default width).
- Divide by zero: result in cycle 1, stallReq_o high in cycle 0 only.
- Upstream advances at the end of the DONE cycle. The next cycle in IDLE sees a new instruction, so there is no re-trigger.
- All state registers update on posedge clk; reset acts asynchronously on negedge rst.

## Configuration
- EX_DIV_EN defined: DIV/REM are implemented as specified.
- EX_DIV_EN undefined:
  - The divider and its sign correction are omitted.
  - DIV/REM behave as undefined codes: wData_o = 0, no stall, divByZero_o = 0.
  - MUL is unaffected.

## Structure
- Shared package `ex_pkg` holds:
  - the ALU_OP_W width;
  - the op enum (NOP, ADD, SUB, AND, OR, NOT, SLL, SRL, SRA, SLT, SLTU, CMP, MUL, DIV, REM);
  - the FSM state typedef;
  - the ZeroWord constant.
- Sub-module `ex_muldiv_iter` contains the FSM, step counter, operand and accumulator registers, and sign correction. It exposes start/op/flush inputs and busy/done/result/dbz outputs.
- The top level keeps the combinational ALU mux and stall/bubble logic.

## Test plan
- ADD 0x7FFF+0x0001 → 0x8000. SRA 0x8000 with s-field 0 → 0xFF80. SLT 0x8000,0x0001 → 1. SLTU 0x8000,0x0001 → 0. No stall on any of these.
- MUL 0x0003 × 0xFFFE → stallReq_o high for 17 cycles, then wData_o = 0xFFFA with wReg_o passed through in DONE.
- DIV 0xFFF9 ÷ 0x0002 → 0xFFFD after 17 stall cycles. REM on the same operands → 0xFFFF. DIV 0x8000 ÷ 0xFFFF → 0x8000, no flag.
- DIV 0x1234 ÷ 0 → 1 stall cycle, then wData_o = 0xFFFF, divByZero_o = 1. REM 0x1234 ÷ 0 → 0x1234, flag 1.
- MUL started, flush_i pulsed in BUSY cycle 5 → stallReq_o = 0 and wReg_o = 0 that cycle, FSM IDLE next cycle. A following ADD completes normally.
- DIV started, rst asserted in BUSY cycle 8 → all outputs 0 immediately, IDLE after release. Without EX_DIV_EN, DIV 6 ÷ 3 → 0, no stall.
